// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detect, bit-centre sampling, LSB-first deserialise, result pulse.
// Build option UART_RX_MAJORITY_VOTE_EN selects a 2-of-3 vote around the bit centre.
module uart_rx_ctrl #(
  parameter int PRESCALE = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       os_tick_i,
  input  logic       rx_in_i,
  input  logic       par_en_i,
  input  logic       parity_error_i,
  input  logic       stop_error_i,
  output logic       ser_bit_o,
  output logic       sample_tick_o,
  output logic       ass_en_o,
  output logic       stop_en_o,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_CTR  = CW'(PRESCALE / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_CHECK
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   os_cnt_q, os_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic            par_en_q, par_en_d;
  logic [7:0]      data_q, data_d;
  logic            ser_bit_q, ser_bit_d;
  logic            sample_tick_q, sample_tick_d;

  logic            bit_end;
  logic            samp_evt;
  logic            samp_val;

  assign bit_end = os_tick_i && (os_cnt_q == CNT_LAST);

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [CW-1:0] CNT_PRE  = CW'(PRESCALE / 2 - 2);
  localparam logic [CW-1:0] CNT_POST = CW'(PRESCALE / 2);

  logic vote_a_q;
  logic vote_b_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vote_a_q <= 1'b0;
      vote_b_q <= 1'b0;
    end else begin
      if (os_tick_i && (os_cnt_q == CNT_PRE)) vote_a_q <= rx_in_i;
      if (os_tick_i && (os_cnt_q == CNT_CTR)) vote_b_q <= rx_in_i;
    end
  end

  // Third vote is the live line value on the tick after the centre.
  assign samp_evt = os_tick_i && (os_cnt_q == CNT_POST);
  assign samp_val = (vote_a_q & vote_b_q) | (vote_a_q & rx_in_i) | (vote_b_q & rx_in_i);
`else
  assign samp_evt = os_tick_i && (os_cnt_q == CNT_CTR);
  assign samp_val = rx_in_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      os_cnt_q      <= '0;
      bit_cnt_q     <= '0;
      par_en_q      <= 1'b0;
      data_q        <= 8'h00;
      ser_bit_q     <= 1'b0;
      sample_tick_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      os_cnt_q      <= os_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      par_en_q      <= par_en_d;
      data_q        <= data_d;
      ser_bit_q     <= ser_bit_d;
      sample_tick_q <= sample_tick_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    os_cnt_d      = os_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    par_en_d      = par_en_q;
    data_d        = data_q;
    ser_bit_d     = ser_bit_q;
    sample_tick_d = 1'b0;
    ass_en_o      = 1'b0;
    stop_en_o     = 1'b0;
    data_valid_o  = 1'b0;
    frame_err_o   = 1'b0;
    busy_o        = (state_q != S_IDLE);

    if (os_tick_i && (state_q != S_IDLE)) begin
      os_cnt_d = bit_end ? '0 : os_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        os_cnt_d = '0;
        if (os_tick_i && !rx_in_i) begin
          state_d  = S_START;
          par_en_d = par_en_i;
        end
      end
      S_START: begin
        // A high sample at the start-bit centre means the falling edge was a glitch.
        if (samp_evt && samp_val) begin
          state_d = S_IDLE;
        end else if (bit_end) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (samp_evt) begin
          sample_tick_d = 1'b1;
          ser_bit_d     = samp_val;
          data_d        = {samp_val, data_q[7:1]};
        end
        if (bit_end) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = par_en_q ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        ass_en_o = 1'b1;
        if (samp_evt) begin
          sample_tick_d = 1'b1;
          ser_bit_d     = samp_val;
        end
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        stop_en_o = 1'b1;
        if (samp_evt) begin
          sample_tick_d = 1'b1;
          ser_bit_d     = samp_val;
        end
        // Leave right after the stop strobe so the next start edge is caught early.
        if (sample_tick_q) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (stop_error_i || (par_en_q && parity_error_i)) frame_err_o = 1'b1;
        else                                               data_valid_o = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ser_bit_o     = ser_bit_q;
  assign sample_tick_o = sample_tick_q;
  assign data_o        = data_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: tick-level line model, checker model, table vectors and random frames.
module tb_uart_rx_ctrl;
  localparam int PRESCALE = 16;
  localparam int BT = 16;

  logic clk = 1'b0;
  logic rst;
  logic os_tick;
  logic rx_in;
  logic par_en;
  logic parity_error = 1'b0;
  logic stop_error = 1'b0;
  logic ser_bit, sample_tick, ass_en, stop_en, data_valid, frame_err, busy;
  logic [7:0] data;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.PRESCALE(PRESCALE)) dut (
    .clk_i(clk), .rst_i(rst), .os_tick_i(os_tick), .rx_in_i(rx_in), .par_en_i(par_en),
    .parity_error_i(parity_error), .stop_error_i(stop_error),
    .ser_bit_o(ser_bit), .sample_tick_o(sample_tick), .ass_en_o(ass_en), .stop_en_o(stop_en),
    .data_o(data), .data_valid_o(data_valid), .frame_err_o(frame_err), .busy_o(busy)
  );

  int checks = 0;
  int errors = 0;
  int n_strobe = 0, n_par_strobe = 0, n_stop_strobe = 0, n_ass = 0, n_busy = 0;
  int n_excl = 0, n_both = 0;
  logic [8:0] res_q[$];
  logic line_q[$];
  logic [7:0] chk_bits = 8'h00;
  logic set_stale = 1'b0;

  typedef struct {
    logic [7:0] d;
    logic pe;
    logic par_ok;
    logic stop;
    logic stale;
    logic exp_ferr;
    int   exp_str;
  } vec_t;
  vec_t vecs[6];

  // Checker model: even parity, stop must be 1; flags update on the strobe cycle.
  always @(negedge clk) begin
    if (set_stale) parity_error = 1'b1;
    if (sample_tick) begin
      if (ass_en) parity_error = (^chk_bits) ^ ser_bit;
      else if (stop_en) stop_error = ~ser_bit;
      else chk_bits = {ser_bit, chk_bits[7:1]};
    end
  end

  always @(posedge clk) begin
    #1;
    if (sample_tick) n_strobe++;
    if (sample_tick && ass_en) n_par_strobe++;
    if (sample_tick && stop_en) n_stop_strobe++;
    if (ass_en) n_ass++;
    if (busy) n_busy++;
    if (ass_en && stop_en) n_excl++;
    if (data_valid && frame_err) n_both++;
    if (data_valid || frame_err) res_q.push_back({frame_err, data});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_tick(input logic v, input int gap);
    rx_in = v;
    repeat (gap - 1) @(negedge clk);
    os_tick = 1'b1;
    @(negedge clk);
    os_tick = 1'b0;
  endtask

  task automatic push_bits(input logic v, input int n);
    repeat (n) line_q.push_back(v);
  endtask

  task automatic build(input logic [7:0] d, input logic pe, input logic par_ok, input logic stop,
                       input int stop_ticks);
    logic pb;
    pb = (^d) ^ ~par_ok;
    push_bits(1'b0, BT);
    for (int i = 0; i < 8; i++) push_bits(d[i], BT);
    if (pe) push_bits(pb, BT);
    push_bits(stop, stop_ticks);
  endtask

  task automatic play(input int n, input int gmin, input int gmax, input bit scramble);
    for (int i = 0; i < n && line_q.size() > 0; i++) begin
      do_tick(line_q.pop_front(), int'($urandom_range(gmax, gmin)));
      if (scramble && i == 0) par_en = 1'($urandom_range(1, 0));
    end
  endtask

  task automatic run_frame(input string nm, input logic [7:0] d, input logic pe, input logic par_ok,
                           input logic stop, input logic stale, input logic exp_ferr,
                           input int exp_str, input int gmin, input int gmax, input bit scramble);
    int s0, p0, t0, a0, r0;
    s0 = n_strobe; p0 = n_par_strobe; t0 = n_stop_strobe; a0 = n_ass; r0 = res_q.size();
    set_stale = stale;
    par_en = pe;
    build(d, pe, par_ok, stop, BT);
    push_bits(1'b1, 2 * BT);
    play(line_q.size(), gmin, gmax, scramble);
    set_stale = 1'b0;
    chk({nm, "_strobes"}, n_strobe - s0, exp_str);
    chk({nm, "_par_strobes"}, n_par_strobe - p0, 32'(pe));
    chk({nm, "_stop_strobes"}, n_stop_strobe - t0, 1);
    chk({nm, "_ass_seen"}, 32'((n_ass - a0) != 0), 32'(pe));
    chk({nm, "_results"}, res_q.size() - r0, 1);
    if (res_q.size() > r0) begin
      chk({nm, "_ferr"}, 32'(res_q[r0][8]), 32'(exp_ferr));
      chk({nm, "_data"}, 32'(res_q[r0][7:0]), 32'(d));
    end
    chk({nm, "_data_held"}, 32'(data), 32'(d));
  endtask

  initial begin
    #3000000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, r0, b0;
    logic [7:0] rd;
    logic rpe, rok, rstop;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10};
    vecs[1] = '{8'h3C, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 9};
    vecs[2] = '{8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 10};
    vecs[3] = '{8'hC3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 10};
    vecs[4] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 9};
    vecs[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10};

    rst = 1'b1; os_tick = 1'b0; rx_in = 1'b1; par_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({ser_bit, sample_tick, ass_en, stop_en, data, data_valid, frame_err, busy}), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    push_bits(1'b1, 4);
    play(line_q.size(), 4, 4, 0);

    for (int i = 0; i < 6; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].d, vecs[i].pe, vecs[i].par_ok, vecs[i].stop,
                vecs[i].stale, vecs[i].exp_ferr, vecs[i].exp_str, 4, 4, 0);
    end

    // Start glitch: low for 4 ticks only.
    s0 = n_strobe; r0 = res_q.size(); b0 = n_busy;
    push_bits(1'b1, 4); push_bits(1'b0, 4); push_bits(1'b1, 24);
    play(line_q.size(), 4, 4, 0);
    chk("glitch_strobes", n_strobe - s0, 0);
    chk("glitch_results", res_q.size() - r0, 0);
    chk("glitch_busy_seen", 32'((n_busy - b0) != 0), 1);
    chk("glitch_busy_end", 32'(busy), 0);

    // Back-to-back frames, next start right after the stop centre.
    s0 = n_strobe; r0 = res_q.size();
    par_en = 1'b0;
    build(8'h55, 1'b0, 1'b1, 1'b1, 10);
    build(8'hAA, 1'b0, 1'b1, 1'b1, BT);
    push_bits(1'b1, 2 * BT);
    play(line_q.size(), 4, 4, 0);
    chk("b2b_strobes", n_strobe - s0, 18);
    chk("b2b_results", res_q.size() - r0, 2);
    if (res_q.size() >= r0 + 2) begin
      chk("b2b_first", 32'(res_q[r0]), 32'({1'b0, 8'h55}));
      chk("b2b_second", 32'(res_q[r0 + 1]), 32'({1'b0, 8'hAA}));
    end

    // Reset in the middle of data bit 4.
    r0 = res_q.size();
    par_en = 1'b0;
    build(8'h6B, 1'b0, 1'b1, 1'b1, BT);
    play(BT + 4 * BT + 8, 4, 4, 0);
    chk("rst_mid_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", 32'({ser_bit, sample_tick, ass_en, stop_en, data, data_valid, frame_err, busy}), 0);
    line_q.delete();
    rx_in = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    push_bits(1'b1, BT);
    play(line_q.size(), 4, 4, 0);
    chk("rst_mid_no_result", res_q.size() - r0, 0);
    run_frame("after_rst", 8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9, 4, 4, 0);

`ifdef UART_RX_MAJORITY_VOTE_EN
    r0 = res_q.size();
    par_en = 1'b0;
    build(8'h5A, 1'b0, 1'b1, 1'b1, BT);
    line_q[BT + 2 * BT + 8] = ~line_q[BT + 2 * BT + 8];
    push_bits(1'b1, 2 * BT);
    play(line_q.size(), 4, 4, 0);
    chk("vote_results", res_q.size() - r0, 1);
    if (res_q.size() > r0) chk("vote_byte", 32'(res_q[r0]), 32'({1'b0, 8'h5A}));
`endif

    // Random frames against the frame-level model.
    for (int k = 0; k < 40; k++) begin
      rd = 8'($urandom);
      rpe = 1'($urandom_range(1, 0));
      rok = ($urandom_range(3, 0) != 0);
      rstop = ($urandom_range(3, 0) != 0);
      run_frame($sformatf("rnd%0d", k), rd, rpe, rok, rstop, 1'b0,
                ~rstop | (rpe & ~rok), 9 + int'(rpe), 1, 4, 1);
    end

    chk("ass_stop_exclusive", n_excl, 0);
    chk("valid_ferr_exclusive", n_both, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
